decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- In-order buffer between the decode stage and the issue/execute stage.
- Receives the decode_data_t bundle (FETCH_WIDTH lanes, each with valid, decoded_instr_t and 64-bit pc) and compacts the valid lanes into a circular FIFO.
- Presents the oldest ISSUE_WIDTH entries to the consumer, which pops a variable number each cycle.
- Flushed on redirect (branch mispredict, exception, mret).

Parameters:
- DEPTH, 16, number of entries; power of two, at least 2*FETCH_WIDTH.
- ISSUE_WIDTH, 2, number of head entries presented per cycle; at most DEPTH.
- FETCH_WIDTH is not a parameter; it is taken from config_pkg.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries; synchronous.
- in_data  input  decode_data_t  incoming bundle; lane i is live when in_data.instr[i].valid is set.
- in_ready  output  1  bundle accepted this cycle when high.
- out_entry  output  ISSUE_WIDTH x {valid, decoded_instr_t, u64 pc}  head entries; element 0 is the oldest.
- deq_cnt  input  $clog2(ISSUE_WIDTH+1)  number of head entries the consumer takes this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage:
  - DEPTH-entry array, read pointer rp and write pointer wp, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy register cnt, driven on count.
- Reset or flush: rp, wp and cnt are 0 on the next cycle. Stored payloads need not be cleared. Outputs while empty:
  - in_ready=1.
  - All out_entry valid=0.
  - count=0.
- in_ready:
  - Combinational: (DEPTH - cnt) >= FETCH_WIDTH.
  - Uses the current cnt only; does not credit a same-cycle dequeue.
  - Does not depend on in_data valid bits.
- Enqueue:
  - Occurs when in_ready=1 and at least one lane is valid.
  - Valid lanes are written in ascending lane order to consecutive slots wp, wp+1, ... (mod DEPTH). Invalid lanes are skipped, e.g. lanes {0 invalid, 1 valid} write lane 1 to slot wp.
  - n_enq = popcount of the lane valid bits; wp advances by n_enq.
  - If in_ready=0 the bundle is ignored. Decode must hold it; nothing is partially accepted.
- Head presentation:
  - Combinational from the stored array: out_entry[k] = slot (rp+k) mod DEPTH.
  - out_entry[k].valid = (k < cnt).
  - Zero-cycle read latency: an entry written at edge N is visible at out_entry during cycle N+1.
- Dequeue:
  - n_deq = min(deq_cnt, cnt, ISSUE_WIDTH). Requests beyond that are silently clamped; no error.
  - rp advances by n_deq.
- Simultaneous enqueue and dequeue: cnt_next = cnt + n_enq - n_deq.
  - The full case (cnt=DEPTH) with a dequeue still gives in_ready=0 that cycle.
- Priority: reset > flush > enqueue/dequeue.
  - A bundle presented together with flush is dropped.
  - deq_cnt is ignored during flush or reset.
- Empty: deq_cnt>0 has no effect.
- Full: cnt never exceeds DEPTH. Guaranteed because enqueue needs FETCH_WIDTH free slots.
- Wrap-around: one bundle may straddle slot DEPTH-1 and slot 0; ordering must be preserved.
- Reset or flush mid-stream: entries already in the queue are lost and never reappear on out_entry.

Optional Feature:
- Macro: DECODE_QUEUE_PERF_EN.
- With the macro defined, two extra outputs:
  - stall_cycles (u64): increments each cycle where any in_data lane is valid and in_ready=0.
  - empty_cycles (u64): increments each cycle where cnt=0 and reset is low.
  - Both counters clear on reset only; flush does not clear them.
- Without the macro these ports and their counters do not exist, and core behaviour is identical.

Test Plan:
- FETCH_WIDTH=2, DEPTH=16, ISSUE_WIDTH=2. Enqueue a bundle with pc 0x80000000/0x80000004, both valid, deq_cnt=0 -> next cycle count=2; out_entry[0].pc=0x80000000, out_entry[1].pc=0x80000004, both valid.
- Lanes {0 invalid, 1 valid, pc 0x80000010} into an empty queue -> out_entry[0].pc=0x80000010, out_entry[1].valid=0, count=1.
- Fill to 15 entries -> in_ready=0. A bundle held 3 cycles is not written (count stays 15) and, with DECODE_QUEUE_PERF_EN, stall_cycles=3. Pop 1 -> in_ready=1 next cycle.
- Count=1, deq_cnt=2 -> count=0 and rp advances by 1 only. Next bundle appears at out_entry[0].
- Advance wp to 15, enqueue 2 entries -> slots 15 and 0 are written; dequeue order is preserved across the wrap.
- Count=8, assert flush together with a valid bundle and deq_cnt=2 -> next cycle count=0, all out_entry invalid, in_ready=1; the dropped bundle never appears.

Source files
------------

// File: rtl/decode_queue.sv
// In-order decode->issue buffer: compacts valid fetch lanes into a circular FIFO.
// Optional DECODE_QUEUE_PERF_EN adds stall_cycles/empty_cycles counters.
package config_pkg;
  localparam int FETCH_WIDTH = 2;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decoded_instr_t;

  typedef struct packed {
    logic           valid;
    decoded_instr_t instr;
    logic [63:0]    pc;
  } dq_entry_t;

  typedef struct packed {
    dq_entry_t [FETCH_WIDTH-1:0] instr;
  } decode_data_t;
endpackage

module decode_queue
  import config_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ISSUE_WIDTH = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  decode_data_t                         in_data,
  output logic                                 in_ready,
  output dq_entry_t [ISSUE_WIDTH-1:0]          out_entry,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]     deq_cnt,
  output logic [$clog2(DEPTH+1)-1:0]           count
`ifdef DECODE_QUEUE_PERF_EN
  ,
  output logic [63:0]                          stall_cycles,
  output logic [63:0]                          empty_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    decoded_instr_t instr;
    logic [63:0]    pc;
  } slot_t;

  slot_t          mem_q [DEPTH];
  slot_t          mem_d [DEPTH];
  logic [PW-1:0]  rp_q, rp_d;
  logic [PW-1:0]  wp_q, wp_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [CW-1:0]  n_enq;
  logic [CW-1:0]  n_deq;
  logic           any_valid;
  logic           do_enq;
  logic [PW-1:0]  off;

  always_comb begin
    n_enq     = '0;
    any_valid = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      n_enq     = n_enq + CW'(in_data.instr[i].valid);
      any_valid = any_valid | in_data.instr[i].valid;
    end
    in_ready = (CW'(DEPTH) - cnt_q) >= CW'(FETCH_WIDTH);
    do_enq   = in_ready && any_valid && !flush;

    n_deq = CW'(deq_cnt);
    if (n_deq > cnt_q) n_deq = cnt_q;
    if (n_deq > CW'(ISSUE_WIDTH)) n_deq = CW'(ISSUE_WIDTH);
    if (flush) n_deq = '0;

    // Valid lanes pack into consecutive slots; invalid lanes leave no hole.
    mem_d = mem_q;
    off   = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (do_enq && in_data.instr[i].valid) begin
        mem_d[wp_q + off] = '{instr: in_data.instr[i].instr,
                              pc:    in_data.instr[i].pc};
        off = off + 1'b1;
      end
    end

    rp_d  = rp_q + PW'(n_deq);
    wp_d  = do_enq ? wp_q + PW'(n_enq) : wp_q;
    cnt_d = cnt_q + (do_enq ? n_enq : '0) - n_deq;
    if (flush) begin
      rp_d  = '0;
      wp_d  = '0;
      cnt_d = '0;
    end
  end

  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      out_entry[k].valid = CW'(k) < cnt_q;
      out_entry[k].instr = mem_q[rp_q + PW'(k)].instr;
      out_entry[k].pc    = mem_q[rp_q + PW'(k)].pc;
    end
    count = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef DECODE_QUEUE_PERF_EN
  logic [63:0] stall_q, stall_d;
  logic [63:0] empty_q, empty_d;

  always_comb begin
    stall_d = stall_q + 64'(any_valid && !in_ready);
    empty_d = empty_q + 64'(cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      empty_q <= '0;
    end else begin
      stall_q <= stall_d;
      empty_q <= empty_d;
    end
  end

  assign stall_cycles = stall_q;
  assign empty_cycles = empty_q;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: driver pushes accepted lanes,
// negedge monitor pops and compares every dequeued head entry.
module tb_decode_queue;
  import config_pkg::*;

  localparam int DEPTH = 16;
  localparam int IW    = 2;

  typedef struct packed {
    decoded_instr_t instr;
    logic [63:0]    pc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    flush;
  decode_data_t            in_data;
  logic                    in_ready;
  dq_entry_t [IW-1:0]      out_entry;
  logic [$clog2(IW+1)-1:0] deq_cnt;
  logic [$clog2(DEPTH+1)-1:0] count;
`ifdef DECODE_QUEUE_PERF_EN
  logic [63:0]             stall_cycles;
  logic [63:0]             empty_cycles;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [63:0] pc;

  decode_queue #(.DEPTH(DEPTH), .ISSUE_WIDTH(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_entry (out_entry),
    .deq_cnt   (deq_cnt),
    .count     (count)
`ifdef DECODE_QUEUE_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .empty_cycles (empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic decoded_instr_t mk(logic [63:0] p);
    decoded_instr_t d;
    d.opcode = p[8:2];
    d.rd     = p[6:2];
    d.rs1    = p[11:7];
    d.rs2    = p[16:12];
    d.imm    = p[31:0] ^ 32'h5a5a_0f0f;
    return d;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(int i, bit v, logic [63:0] p);
    in_data.instr[i].valid = v;
    in_data.instr[i].instr = mk(p);
    in_data.instr[i].pc    = p;
  endtask

  task automatic drive(bit v0, logic [63:0] p0,
                       bit v1, logic [63:0] p1, bit acc);
    set_lane(0, v0, p0);
    set_lane(1, v1, p1);
    chk("in_ready_pre", 64'(in_ready), 64'(acc));
    if (acc && v0) sb.push_back('{instr: mk(p0), pc: p0});
    if (acc && v1) sb.push_back('{instr: mk(p1), pc: p1});
    cyc();
    in_data = '0;
  endtask

  task automatic pair(bit acc);
    drive(1'b1, pc, 1'b1, pc + 64'd4, acc);
    pc = pc + 64'd8;
  endtask

  always @(negedge clk) begin
    if (!reset && !flush) begin
      for (int k = 0; k < IW; k++) begin
        if (k < int'(deq_cnt) && out_entry[k].valid) begin
          exp_t got;
          exp_t e;
          got = '{instr: out_entry[k].instr, pc: out_entry[k].pc};
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL deq_extra: got pc %0h expected none", got.pc);
          end else begin
            e = sb.pop_front();
            if (got !== e) begin
              n_bad++;
              $display("FAIL deq_order: got pc %0h expected pc %0h",
                       got.pc, e.pc);
            end
          end
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    in_data = '0;
    deq_cnt = '0;
    pc      = 64'h8000_1000;
    cyc();
    cyc();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'({out_entry[1].valid, out_entry[0].valid}), 64'd0);
    reset = 1'b0;

    drive(1'b1, 64'h8000_0000, 1'b1, 64'h8000_0004, 1'b1);
    chk("two_count", 64'(count), 64'd2);
    chk("two_pc0", out_entry[0].pc, 64'h8000_0000);
    chk("two_pc1", out_entry[1].pc, 64'h8000_0004);
    chk("two_valid", 64'({out_entry[1].valid, out_entry[0].valid}), 64'd3);
    deq_cnt = 2'd2;
    cyc();
    deq_cnt = 2'd0;
    chk("two_drained", 64'(count), 64'd0);

    drive(1'b0, 64'h8000_0008, 1'b1, 64'h8000_0010, 1'b1);
    chk("skip_pc0", out_entry[0].pc, 64'h8000_0010);
    chk("skip_v1", 64'(out_entry[1].valid), 64'd0);
    chk("skip_count", 64'(count), 64'd1);

    deq_cnt = 2'd2;
    cyc();
    deq_cnt = 2'd0;
    chk("clamp_count", 64'(count), 64'd0);
    drive(1'b1, 64'h8000_0020, 1'b1, 64'h8000_0024, 1'b1);
    chk("clamp_next_pc0", out_entry[0].pc, 64'h8000_0020);
    chk("clamp_next_pc1", out_entry[1].pc, 64'h8000_0024);
    deq_cnt = 2'd2;
    cyc();
    deq_cnt = 2'd0;

    for (int i = 0; i < 7; i++) pair(1'b1);
    chk("fill14_count", 64'(count), 64'd14);
    chk("fill14_in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, pc, 1'b0, 64'h0, 1'b1);
    pc = pc + 64'd4;
    chk("fill15_count", 64'(count), 64'd15);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'hdead_0000, 1'b1, 64'hdead_0004, 1'b0);
    end
    chk("hold_count", 64'(count), 64'd15);
`ifdef DECODE_QUEUE_PERF_EN
    chk("stall_cycles", stall_cycles, 64'd3);
`endif
    deq_cnt = 2'd1;
    cyc();
    deq_cnt = 2'd0;
    chk("pop1_in_ready", 64'(in_ready), 64'd1);
    chk("pop1_count", 64'(count), 64'd14);
    pair(1'b1);
    chk("full_count", 64'(count), 64'd16);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    deq_cnt = 2'd2;
    drive(1'b1, 64'hdead_0010, 1'b1, 64'hdead_0014, 1'b0);
    deq_cnt = 2'd0;
    chk("full_deq_count", 64'(count), 64'd14);
    chk("full_deq_in_ready", 64'(in_ready), 64'd1);
    deq_cnt = 2'd2;
    for (int i = 0; i < 7; i++) cyc();
    deq_cnt = 2'd0;
    chk("wrap_drained", 64'(count), 64'd0);

    for (int i = 0; i < 4; i++) pair(1'b1);
    chk("pre_flush_count", 64'(count), 64'd8);
    flush   = 1'b1;
    deq_cnt = 2'd2;
    set_lane(0, 1'b1, 64'hbad0_0000);
    set_lane(1, 1'b1, 64'hbad0_0004);
    sb.delete();
    cyc();
    flush   = 1'b0;
    in_data = '0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'({out_entry[1].valid, out_entry[0].valid}), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    cyc();
    cyc();
    deq_cnt = 2'd0;
    chk("post_flush_count", 64'(count), 64'd0);
    drive(1'b1, 64'ha000_0000, 1'b1, 64'ha000_0004, 1'b1);
    chk("post_flush_pc0", out_entry[0].pc, 64'ha000_0000);
    deq_cnt = 2'd2;
    cyc();
    deq_cnt = 2'd0;
    chk("final_count", 64'(count), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
